// File: rtl/rf_dbg_pkg.sv
// Shared sizes and FSM state type for the register-file
// debug dump reader.
package rf_dbg_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    FIN
  } state_e;

endpackage

// File: rtl/rf_dump_reader.sv
// Walks a register range through one read port and streams
// (index, value) pairs to a debug sink over valid/ready.
module rf_dump_reader
  import rf_dbg_pkg::*;
#(
  parameter int NUM_REGS = rf_dbg_pkg::NUM_REGS,
  parameter int ADDR_W   = rf_dbg_pkg::ADDR_W,
  parameter int DATA_W   = rf_dbg_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rs_addr,
  input  logic [DATA_W-1:0] rs_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] MAX_IDX =
    ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] cnt_inc;

  assign cnt_inc = (cnt_q == MAX_IDX) ? '0
                 : cnt_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    idx_d   = idx_q;
    data_d  = data_q;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            cnt_d   = first_reg;
            last_d  = last_reg;
            state_d = READ;
          end
        end
        READ: begin
          idx_d   = cnt_q;
          data_d  = rs_data;
          state_d = SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (cnt_q == last_q) begin
              state_d = FIN;
            end else begin
              cnt_d   = cnt_inc;
              state_d = READ;
            end
          end
        end
        FIN: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign rs_addr   = cnt_q;
  assign out_valid = (state_q == SEND);
  assign out_idx   = idx_q;
  assign out_data  = data_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench: behavioural register file feeding the dump
// reader, with a shadow copy holding expected contents.
module tb_rf_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic [4:0]  rs_addr;
  logic [31:0] rs_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] regs [32];
  logic [31:0] mdl [32];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (we) regs[wa] <= wd;

  assign rs_data = regs[rs_addr];

  rf_dump_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .rs_addr   (rs_addr),
    .rs_data   (rs_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    we = 1'b1;
    wa = 5'(a);
    wd = d;
    step();
    we = 1'b0;
    mdl[a] = d;
  endtask

  // Start a dump with ready held high and check every word
  // at the two-cycle cadence, then the done pulse.
  task automatic do_dump(input int f, input int l);
    int n;
    int idx;
    first_reg = 5'(f);
    last_reg  = 5'(l);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_nvld", 32'(out_valid), 32'd0);
    step();
    n = ((l - f + 32) % 32) + 1;
    idx = f;
    for (int k = 0; k < n; k++) begin
      chk("w_valid", 32'(out_valid), 32'd1);
      chk("w_idx", 32'(out_idx), 32'(idx));
      chk("w_data", out_data, mdl[idx]);
      step();
      if (k < n - 1) begin
        chk("rd_nvld", 32'(out_valid), 32'd0);
        chk("rd_ndone", 32'(done), 32'd0);
        step();
      end
      idx = (idx + 1) % 32;
    end
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_nvld", 32'(out_valid), 32'd0);
    step();
    chk("end_done", 32'(done), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    first_reg = '0;
    last_reg  = '0;
    out_ready = 1'b1;
    we = 1'b0;
    wa = '0;
    wd = '0;
    @(negedge clk);
    step();
    chk("rst_addr", 32'(rs_addr), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      if (i == 1)
        wr(i, 32'h1);
      else if (i == 2)
        wr(i, 32'hff);
      else if (i >= 3 && i <= 12)
        wr(i, 32'(i));
      else
        wr(i, 32'h0);
    end

    do_dump(0, 31);
    do_dump(5, 5);
    wr(30, 32'hAA);
    wr(31, 32'hBB);
    do_dump(30, 2);

    // backpressure on range 1..3
    first_reg = 5'd1;
    last_reg  = 5'd3;
    out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int c = 0; c < 2; c++) begin
      chk("bp1_vld", 32'(out_valid), 32'd1);
      chk("bp1_idx", 32'(out_idx), 32'd1);
      step();
    end
    out_ready = 1'b1;
    chk("bp1_data", out_data, 32'h1);
    step();
    out_ready = 1'b0;
    step();
    for (int c = 0; c < 10; c++) begin
      chk("bp2_vld", 32'(out_valid), 32'd1);
      chk("bp2_idx", 32'(out_idx), 32'd2);
      chk("bp2_data", out_data, 32'hff);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_rd", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    step();
    chk("bp3_idx", 32'(out_idx), 32'd3);
    out_ready = 1'b1;
    chk("bp3_data", out_data, 32'h3);
    step();
    chk("bp_done", 32'(done), 32'd1);
    step();
    chk("bp_idle", 32'(busy), 32'd0);

    // abort during SEND of idx 4
    first_reg = 5'd0;
    last_reg  = 5'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 9; c++) step();
    chk("ab_idx", 32'(out_idx), 32'd4);
    chk("ab_vld", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_nvld", 32'(out_valid), 32'd0);
    chk("ab_ndone", 32'(done), 32'd0);
    step();
    chk("ab_ndone2", 32'(done), 32'd0);
    out_ready = 1'b1;

    // reset during SEND of idx 4
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 9; c++) step();
    chk("rs_idx", 32'(out_idx), 32'd4);
    out_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_addr", 32'(rs_addr), 32'd0);
    chk("mrst_vld", 32'(out_valid), 32'd0);
    chk("mrst_idx", 32'(out_idx), 32'd0);
    chk("mrst_data", out_data, 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    out_ready = 1'b1;

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);

    // start while busy, write racing the READ of idx 3
    first_reg = 5'd0;
    last_reg  = 5'd7;
    start = 1'b1;
    step();
    first_reg = 5'd20;
    last_reg  = 5'd20;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("sb_vld", 32'(out_valid), 32'd1);
      chk("sb_idx", 32'(out_idx), 32'(k));
      chk("sb_data", out_data, mdl[k]);
      step();
      if (k < 7) begin
        if (k == 2) begin
          we = 1'b1;
          wa = 5'd3;
          wd = 32'h1234;
        end
        step();
        we = 1'b0;
      end
    end
    mdl[3] = 32'h1234;
    chk("sb_done", 32'(done), 32'd1);
    step();
    do_dump(3, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
